spi_flash_responder: RTL
========================

Name: spi_flash_responder

Overview:
- SPI Mode 0 (CPOL=0, CPHA=0) slave that emulates the serial-flash READ (0x03) and PAGE PROGRAM (0x02) commands.
- An external SPI master (FT2232 host link) uses it to read and load the on-chip boot/program RAM that the 6809 executes from.
- SPI pins are asynchronous to clk. They are synchronised and edge-detected internally, then converted into single-cycle RAM read/write strobes.

Parameters:
- ADDR_W, 16, width of the RAM address port. Received 24-bit addresses are truncated to the low ADDR_W bits.

Ports:
- clk  input  1  system clock
- i_RESET  input  1  asynchronous, active-high reset
- i_SPI_CLK  input  1  SPI clock from master; frequency ≤ clk/8
- i_SPI_MOSI  input  1  master-out data
- i_SPI_CS  input  1  chip select, active low
- o_SPI_MISO  output  1  slave-out data
- o_SPI_MISO_OE  output  1  MISO output enable; top level tristates MISO when 0
- o_MEM_ADDR  output  ADDR_W  RAM address
- o_MEM_RD  output  1  one-cycle read strobe; RAM returns i_MEM_DATA exactly 1 clk later
- i_MEM_DATA  input  8  RAM read data
- o_MEM_WR  output  1  one-cycle write strobe
- o_MEM_WDATA  output  8  RAM write data, valid while o_MEM_WR=1
- o_BUSY  output  1  high while i_SPI_CS (synchronised) is low

Behaviour:
- Reset values: all outputs 0; state IDLE; counters and shift registers 0. Reset is asynchronous and may arrive mid-transaction; after release, the block waits for a CS high→low edge before decoding anything.
- Synchronisation: 2-flop synchroniser on each of SCK, MOSI and CS.
  - rise/fall = single-cycle pulses derived from synchronised SCK.
  - cs_act = synchronised CS low.
- States:
  - IDLE: CS falling → CMD, bit_cnt=0.
  - CMD: shift MOSI MSB-first on each rise. After 8 bits: 0x03 or 0x02 → ADDR; any other value → IGNORE.
  - ADDR: shift 24 bits MSB-first. On the 24th rise, latch addr = low ADDR_W bits, then go to READ_DATA (cmd 0x03) or WRITE_DATA (cmd 0x02).
  - READ_DATA:
    - On entry, pulse o_MEM_RD with o_MEM_ADDR=addr. One clk later, load tx_shift=i_MEM_DATA.
    - The first following SCK fall drives o_SPI_MISO=bit7. Each subsequent fall shifts the next bit out.
    - On the rise of bit 7 of each byte: addr=addr+1, pulse o_MEM_RD; the loaded byte's bit7 is driven on the next fall.
    - Streaming continues until CS high.
  - WRITE_DATA:
    - Shift MOSI on rise.
    - Every 8th bit: one-cycle o_MEM_WR with o_MEM_ADDR=addr and o_MEM_WDATA=byte; then addr=addr+1.
    - No page-boundary wrap; only ADDR_W wrap.
  - IGNORE: no RAM activity, MISO not driven, until CS high.
- Any state, CS goes high → IDLE the next clk.
  - A partial write byte is discarded with no o_MEM_WR.
  - o_SPI_MISO_OE drops in the same clk.
  - An in-flight read strobe is allowed to complete; its data is discarded.
- Address arithmetic: addr+1 wraps modulo 2^ADDR_W (0xFFFF→0x0000).
- o_SPI_MISO_OE=1 only in READ_DATA. Otherwise o_SPI_MISO=0 and OE=0.
- o_MEM_RD and o_MEM_WR are never high in the same clk.
- Timing budget: SCK ≤ clk/8 guarantees ≥4 clks from the rise that issues a read to the next fall. The path is 1 strobe clk + 1 data clk + 1 load clk.
- MISO updates only on fall-detect, never on rise.

Test Plan:
- Read: mem[0x1234]=0xA5, mem[0x1235]=0x3C; master sends 03 00 12 34 then clocks 16 bits → MISO bytes A5, 3C; o_MEM_RD pulses at addr 0x1234 then 0x1235; OE=1 only after the 32nd bit.
- Wrap: read from address 0x00FFFF with mem[0xFFFF]=0x11, mem[0x0000]=0x22 → MISO 11, 22; second strobe at o_MEM_ADDR=0x0000. Address 0xAB0005 → RAM addr 0x0005.
- Write: master sends 02 00 00 10 11 22 then 4 extra bits then CS high → exactly two o_MEM_WR pulses (0x0010←0x11, 0x0011←0x22); the partial byte produces no write.
- Abort/unknown: CS high after 12 address bits → no RAM strobes; the following full READ works normally. Command 0x9F + 32 clocks → no strobes, OE stays 0.
- Reset: assert i_RESET mid-READ_DATA byte → all outputs 0 immediately. After release, SCK toggling with CS held low produces no strobes; a new CS-fall READ succeeds.
- Throughput: run SCK at exactly clk/8 for a 64-byte read → every bit matches RAM and no bit slips.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI mode-0 serial-flash responder: READ (0x03) and PAGE PROGRAM (0x02) mapped onto
// single-cycle RAM read/write strobes for the 6809 boot/program RAM.
module spi_flash_responder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              i_RESET,
    input  logic              i_SPI_CLK,
    input  logic              i_SPI_MOSI,
    input  logic              i_SPI_CS,
    output logic              o_SPI_MISO,
    output logic              o_SPI_MISO_OE,
    output logic [ADDR_W-1:0] o_MEM_ADDR,
    output logic              o_MEM_RD,
    input  logic [7:0]        i_MEM_DATA,
    output logic              o_MEM_WR,
    output logic [7:0]        o_MEM_WDATA,
    output logic              o_BUSY
);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t state_reg, state_next;

    logic [1:0]        sck_sync_reg, mosi_sync_reg, cs_sync_reg;
    logic              sck_prev_reg, cs_act_prev_reg;
    logic [4:0]        bit_cnt_reg;
    logic [ADDR_W-2:0] shift_reg;
    logic              is_read_reg;
    logic [ADDR_W-1:0] addr_reg, mem_addr_reg;
    logic [7:0]        tx_shift_reg, wdata_reg;
    logic              miso_reg, rd_reg, wr_reg, load_reg, busy_reg;

    logic              rise, fall, cs_act, cs_fall, mosi;
    logic [7:0]        byte_in;
    logic [ADDR_W-1:0] addr_in;
    logic              oe;

    // The sync flops reset to 0 (CS looks active) and the previous-CS flag to
    // active, so a CS held low across reset never produces a falling edge.
    assign rise    = sck_sync_reg[1] & ~sck_prev_reg;
    assign fall    = ~sck_sync_reg[1] & sck_prev_reg;
    assign cs_act  = ~cs_sync_reg[1];
    assign cs_fall = cs_act & ~cs_act_prev_reg;
    assign mosi    = mosi_sync_reg[1];
    assign byte_in = {shift_reg[6:0], mosi};
    assign addr_in = {shift_reg, mosi};

    always_ff @(posedge clk or posedge i_RESET) begin
        if (i_RESET) begin
            sck_sync_reg    <= '0;
            mosi_sync_reg   <= '0;
            cs_sync_reg     <= '0;
            sck_prev_reg    <= 1'b0;
            cs_act_prev_reg <= 1'b1;
            busy_reg        <= 1'b0;
        end else begin
            sck_sync_reg    <= {sck_sync_reg[0], i_SPI_CLK};
            mosi_sync_reg   <= {mosi_sync_reg[0], i_SPI_MOSI};
            cs_sync_reg     <= {cs_sync_reg[0], i_SPI_CS};
            sck_prev_reg    <= sck_sync_reg[1];
            cs_act_prev_reg <= cs_act;
            busy_reg        <= cs_act;
        end
    end

    always_ff @(posedge clk or posedge i_RESET) begin
        if (i_RESET) state_reg <= S_IDLE;
        else         state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (!cs_act) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: if (cs_fall) state_next = S_CMD;
                S_CMD: begin
                    if (rise && bit_cnt_reg == 5'd7)
                        state_next = (byte_in == 8'h03 || byte_in == 8'h02) ? S_ADDR : S_IGNORE;
                end
                S_ADDR: begin
                    if (rise && bit_cnt_reg == 5'd23)
                        state_next = is_read_reg ? S_READ : S_WRITE;
                end
                default: state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        oe            = (state_reg == S_READ) && cs_act;
        o_SPI_MISO_OE = oe;
        o_SPI_MISO    = oe & miso_reg;
        o_MEM_ADDR    = mem_addr_reg;
        o_MEM_RD      = rd_reg;
        o_MEM_WR      = wr_reg;
        o_MEM_WDATA   = wdata_reg;
        o_BUSY        = busy_reg;
    end

    // tx_shift is reloaded the clock after each read strobe; the SCK timing
    // bound keeps that reload clear of the next fall.
    always_ff @(posedge clk or posedge i_RESET) begin
        if (i_RESET) begin
            tx_shift_reg <= '0;
            load_reg     <= 1'b0;
        end else begin
            load_reg <= rd_reg;
            if (load_reg)
                tx_shift_reg <= i_MEM_DATA;
            else if (state_reg == S_READ && cs_act && fall)
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge i_RESET) begin
        if (i_RESET) begin
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            is_read_reg  <= 1'b0;
            addr_reg     <= '0;
            mem_addr_reg <= '0;
            wdata_reg    <= '0;
            miso_reg     <= 1'b0;
            rd_reg       <= 1'b0;
            wr_reg       <= 1'b0;
        end else begin
            rd_reg <= 1'b0;
            wr_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    bit_cnt_reg <= '0;
                    shift_reg   <= '0;
                    miso_reg    <= 1'b0;
                end
                S_CMD: begin
                    if (cs_act && rise) begin
                        shift_reg <= addr_in[ADDR_W-2:0];
                        if (bit_cnt_reg == 5'd7) begin
                            is_read_reg <= (byte_in == 8'h03);
                            bit_cnt_reg <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (cs_act && rise) begin
                        shift_reg <= addr_in[ADDR_W-2:0];
                        if (bit_cnt_reg == 5'd23) begin
                            addr_reg     <= addr_in;
                            mem_addr_reg <= addr_in;
                            rd_reg       <= is_read_reg;
                            bit_cnt_reg  <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                S_READ: begin
                    if (cs_act && fall)
                        miso_reg <= tx_shift_reg[7];
                    // Last bit of a byte fetches the next one ahead of its first fall.
                    if (cs_act && rise) begin
                        if (bit_cnt_reg == 5'd7) begin
                            addr_reg     <= addr_reg + ADDR_ONE;
                            mem_addr_reg <= addr_reg + ADDR_ONE;
                            rd_reg       <= 1'b1;
                            bit_cnt_reg  <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                S_WRITE: begin
                    if (cs_act && rise) begin
                        shift_reg <= addr_in[ADDR_W-2:0];
                        if (bit_cnt_reg == 5'd7) begin
                            wr_reg       <= 1'b1;
                            wdata_reg    <= byte_in;
                            mem_addr_reg <= addr_reg;
                            addr_reg     <= addr_reg + ADDR_ONE;
                            bit_cnt_reg  <= '0;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
